// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
// In-order instruction queue between fetch and decode. Holds {pc, pc_plus4, instr}
// triples in a DEPTH-entry circular buffer with valid/ready handshakes on both sides.
// A flush (branch/jump/interrupt redirect) discards every buffered entry.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an entry arriving at an
// empty queue pass straight to decode in the same cycle when decode is ready.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_pc_plus4,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc_plus4,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] L_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);
    localparam logic [31:0] L_NOP   = 32'h0000_0013;

    // Entry payload storage; contents are don't-care after reset or flush
    logic [95:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [95:0]   w_head;

    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with decode ready: hand the fetch entry straight through, no write
    assign w_bypass = w_empty & in_valid & out_ready & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Full blocks a push even when a pop happens in the same cycle
    assign in_ready  = (r_count != L_FULL);
    assign out_valid = w_bypass | (~w_empty & ~flush);

    assign w_push = in_valid & in_ready & ~flush & ~w_bypass;
    assign w_pop  = ~w_empty & out_ready & ~flush;

    // Head selection: bypassed input, stored head, or a NOP bubble when nothing is valid
    always_comb begin
        out_pc       = 32'h0;
        out_pc_plus4 = 32'h0;
        out_instr    = L_NOP;
        if (w_bypass) begin
            out_pc       = in_pc;
            out_pc_plus4 = in_pc_plus4;
            out_instr    = in_instr;
        end else if (out_valid) begin
            out_pc       = w_head[95:64];
            out_pc_plus4 = w_head[63:32];
            out_instr    = w_head[31:0];
        end
    end

    // Payload write at the tail; storage needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_pc_plus4, in_instr};
        end
    end

    // Pointer and occupancy bookkeeping; flush clears everything and drops push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + L_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - L_ONE;
            end
        end
    end

    assign count = r_count;

endmodule
